// File: rtl/rv_exec_pkg.sv
// Purpose: shared types and constants for the multicycle execute stage.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package rv_exec_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_SUB    = 4'd1,
        OP_AND    = 4'd2,
        OP_OR     = 4'd3,
        OP_XOR    = 4'd4,
        OP_SLT    = 4'd5,
        OP_SLTU   = 4'd6,
        OP_SLL    = 4'd7,
        OP_SRL    = 4'd8,
        OP_SRA    = 4'd9,
        OP_MUL    = 4'd10,
        OP_BRANCH = 4'd11,
        OP_JAL    = 4'd12,
        OP_JALR   = 4'd13
    } exec_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } exec_state_t;

    localparam logic [2:0] BR_BEQ  = 3'b000;
    localparam logic [2:0] BR_BNE  = 3'b001;
    localparam logic [2:0] BR_BLT  = 3'b100;
    localparam logic [2:0] BR_BGE  = 3'b101;
    localparam logic [2:0] BR_BLTU = 3'b110;
    localparam logic [2:0] BR_BGEU = 3'b111;

    // Branch decision from precomputed compare flags; reserved encodings are never taken.
    function automatic logic branch_taken(input logic [2:0] func3,
                                          input logic eq,
                                          input logic lt,
                                          input logic ltu);
        logic t;
        case (func3)
            BR_BEQ:  t = eq;
            BR_BNE:  t = !eq;
            BR_BLT:  t = lt;
            BR_BGE:  t = !lt;
            BR_BLTU: t = ltu;
            BR_BGEU: t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/rv_mul_iter.sv
// Purpose: iterative shift-add multiplier retiring MUL_RADIX multiplier bits per step.
// Latency: XLEN/MUL_RADIX steps after load; product is valid combinationally during the final step.
// Backpressure: none; the caller sequences load/step and counts steps.
// Ports: clk; load (capture operands, clear accumulator); multiplicand, multiplier (XLEN);
//        step (retire one digit); product (accumulator including the digit retired this cycle).
module rv_mul_iter
    import rv_exec_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MUL_RADIX = 1
) (
    input  logic            clk,
    input  logic            load,
    input  logic [XLEN-1:0] multiplicand,
    input  logic [XLEN-1:0] multiplier,
    input  logic            step,
    output logic [XLEN-1:0] product
);

    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] partial;

    // Partial product for the low MUL_RADIX bits of the remaining multiplier.
    always_comb begin
        partial = '0;
        for (int i = 0; i < MUL_RADIX; i++) begin
            if (mplier[i]) begin
                partial = partial + (mcand << i);
            end
        end
    end

    // Exposing acc+partial lets the caller capture the final product on the last step edge.
    assign product = acc + partial;

    always_ff @(posedge clk) begin
        if (load) begin
            acc    <= '0;
            mcand  <= multiplicand;
            mplier <= multiplier;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << MUL_RADIX;
            mplier <= mplier >> MUL_RADIX;
        end
    end

endmodule

// File: rtl/rv_exec_unit.sv
// Purpose: multicycle execute stage: ALU, iterative multiply, branch/jump target and PC-load decision.
// Latency: 1 cycle for ALU/branch/jump ops; XLEN/MUL_RADIX+1 cycles for OP_MUL.
// Backpressure: ready=0 while multiplying; a start seen with ready=0 is dropped, not queued.
// Ports: clk, reset (sync, active-high); start, op, func3, a, b, imm, pc in;
//        ready, done (1-cycle pulse), result, pc_load, pc_next out (all registered).
module rv_exec_unit
    import rv_exec_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int MUL_RADIX = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] pc,
    output logic            ready,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            pc_load,
    output logic [XLEN-1:0] pc_next
);

    localparam int SHW   = $clog2(XLEN);
    localparam int STEPS = XLEN / MUL_RADIX;
    localparam int CW    = $clog2(STEPS + 1);

    if (!(XLEN == 32 || XLEN == 64) ||
        !(MUL_RADIX == 1 || MUL_RADIX == 2 || MUL_RADIX == 4) ||
        (XLEN % MUL_RADIX) != 0) begin : g_param_check
        $error("rv_exec_unit: illegal XLEN=%0d / MUL_RADIX=%0d", XLEN, MUL_RADIX);
    end

    exec_state_t     state;
    logic [CW-1:0]   cnt;
    exec_op_t        op_e;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] rel_target;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] diff;
    logic            eq;
    logic            lt;
    logic            ltu;
    logic [XLEN-1:0] result_d;
    logic            pc_load_d;
    logic [XLEN-1:0] pc_next_d;
    logic            mul_load;
    logic            mul_step;
    logic [XLEN-1:0] mul_product;

    assign op_e  = exec_op_t'(op);
    assign shamt = b[SHW-1:0];

    // Shared compare/target arithmetic.
    always_comb begin
        seq_pc         = pc + XLEN'(4);
        rel_target     = pc + imm;
        jalr_target    = a + imm;
        jalr_target[0] = 1'b0;
        diff           = a - b;
        eq             = (a == b);
        lt             = ($signed(a) < $signed(b));
        ltu            = (a < b);
    end

    // Single-cycle result and PC decision; OP_MUL only contributes pc_next here.
    always_comb begin
        result_d  = '0;
        pc_load_d = 1'b0;
        pc_next_d = seq_pc;
        case (op_e)
            OP_ADD:  result_d = a + b;
            OP_SUB:  result_d = diff;
            OP_AND:  result_d = a & b;
            OP_OR:   result_d = a | b;
            OP_XOR:  result_d = a ^ b;
            OP_SLT:  result_d = {{(XLEN-1){1'b0}}, lt};
            OP_SLTU: result_d = {{(XLEN-1){1'b0}}, ltu};
            OP_SLL:  result_d = a << shamt;
            OP_SRL:  result_d = a >> shamt;
            OP_SRA:  result_d = $signed(a) >>> shamt;
            OP_BRANCH: begin
                result_d = diff;
                if (branch_taken(func3, eq, lt, ltu)) begin
                    pc_load_d = 1'b1;
                    pc_next_d = rel_target;
                end
            end
            OP_JAL: begin
                result_d  = seq_pc;
                pc_load_d = 1'b1;
                pc_next_d = rel_target;
            end
            OP_JALR: begin
                result_d  = seq_pc;
                pc_load_d = 1'b1;
                pc_next_d = jalr_target;
            end
            default: result_d = '0;
        endcase
    end

    // ready is 1 exactly in IDLE/DONE, so start&&ready is the accept condition.
    assign mul_load = start && ready && (op_e == OP_MUL);
    assign mul_step = (state == ST_MUL);

    rv_mul_iter #(
        .XLEN      (XLEN),
        .MUL_RADIX (MUL_RADIX)
    ) u_mul (
        .clk          (clk),
        .load         (mul_load),
        .multiplicand (a),
        .multiplier   (b),
        .step         (mul_step),
        .product      (mul_product)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            ready   <= 1'b1;
            done    <= 1'b0;
            pc_load <= 1'b0;
            result  <= '0;
            pc_next <= '0;
        end else begin
            // done and pc_load are pulses unless re-asserted below.
            done    <= 1'b0;
            pc_load <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pc_next <= pc_next_d;
                        if (op_e == OP_MUL) begin
                            state <= ST_MUL;
                            ready <= 1'b0;
                            cnt   <= CW'(STEPS);
                        end else begin
                            state   <= ST_DONE;
                            done    <= 1'b1;
                            pc_load <= pc_load_d;
                            result  <= result_d;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_MUL: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state  <= ST_DONE;
                        ready  <= 1'b1;
                        done   <= 1'b1;
                        result <= mul_product;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
